mem_port_arbiter: RTL

- Shares the single-ported data/instruction memory between two requesters: the instruction-fetch path (F) and the load/store path (D) driven by control_unit.
- Grants one requester at a time and holds its address, write-enable and write data stable for a fixed-latency access.
- Returns read data with a one-cycle done pulse.
- Drives a busy flag so control_unit can stall PC load and register writes.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared single-ported memory: fetch (F) versus load/store (D).
// Holds the granted request stable for WAIT_CYCLES+1 cycles, then pulses done with the read data.
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int FIXED_PRI   = 0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic              f_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       last_d;   // 1 when D won the previous arbitration
    logic       owner_d;
    logic       pick_f, pick_d;

    // F wins a tie under fixed priority, or when D had the last turn
    always_comb begin
        pick_f = f_req && (!d_req || (FIXED_PRI != 0) || last_d);
        pick_d = d_req && !pick_f;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_f || pick_d) begin
                        state    <= BUSY;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        f_gnt    <= pick_f;
                        d_gnt    <= pick_d;
                        owner_d  <= pick_d;
                        last_d   <= pick_d;
                        cnt      <= WAIT_INIT;
                        mem_addr <= pick_d ? d_addr : f_addr;
                        mem_wr   <= pick_d & d_wr;
                        if (pick_d) mem_wdata <= d_wdata;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!mem_wr) rdata <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        f_gnt  <= 1'b0;
                        d_gnt  <= 1'b0;
                        f_done <= !owner_d;
                        d_done <= owner_d;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    f_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
